// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } div_state_t;

    function automatic int CNT_W(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Radix-2 restoring divider: one quotient bit per clock, signed/unsigned per operation.
// Quotient feeds LO, remainder feeds HI; a zero divisor is flagged with div_by_zero.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             clr_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = CNT_W(WIDTH);

    div_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_rem, r_q, r_dvsr;
    logic [CW-1:0]    r_cnt;
    logic             r_sgn, r_qneg, r_rneg, r_dbz;
    logic             r_busy, r_done, r_dbz_out;
    logic [WIDTH-1:0] r_quo, r_rmd;

    logic             w_dvsr_zero, w_busy_nxt, w_done_nxt;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag, w_quo_fix, w_rem_fix;

    assign w_dvsr_zero = (r_dvsr == '0);
    assign w_dvd_mag   = (r_sgn && r_q[WIDTH-1])    ? -r_q    : r_q;
    assign w_dvs_mag   = (r_sgn && r_dvsr[WIDTH-1]) ? -r_dvsr : r_dvsr;
    // Trial subtract on the shifted partial remainder, one bit wider so the borrow is visible
    assign w_trial     = {r_rem, r_q[WIDTH-1]} - {1'b0, r_dvsr};
    assign w_quo_fix   = r_qneg ? -r_q   : r_q;
    assign w_rem_fix   = r_rneg ? -r_rem : r_rem;

    always_ff @(posedge Clock or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // A zero divisor bypasses ITER; FIX then loads the divide-by-zero result
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_PREP;
            ST_PREP: w_state_nxt = w_dvsr_zero ? ST_FIX : ST_ITER;
            ST_ITER: if (r_cnt == '0) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = start ? ST_PREP : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt = (w_state_nxt == ST_PREP) || (w_state_nxt == ST_ITER) ||
                     (w_state_nxt == ST_FIX);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge Clock or negedge clr_n) begin
        if (!clr_n) begin
            r_rem     <= '0;
            r_q       <= '0;
            r_dvsr    <= '0;
            r_cnt     <= '0;
            r_sgn     <= 1'b0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_dbz     <= 1'b0;
            r_quo     <= '0;
            r_rmd     <= '0;
            r_dbz_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_q       <= dividend;
                        r_dvsr    <= divisor;
                        r_sgn     <= is_signed;
                        r_dbz_out <= 1'b0;
                    end
                end
                ST_PREP: begin
                    r_rem  <= '0;
                    r_cnt  <= CW'(WIDTH - 1);
                    r_dbz  <= w_dvsr_zero;
                    r_qneg <= r_sgn & (r_q[WIDTH-1] ^ r_dvsr[WIDTH-1]);
                    r_rneg <= r_sgn & r_q[WIDTH-1];
                    r_dvsr <= w_dvs_mag;
                    // Keep the raw dividend for the divide-by-zero remainder
                    if (!w_dvsr_zero) r_q <= w_dvd_mag;
                end
                ST_ITER: begin
                    r_q   <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
                    r_rem <= w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_q[WIDTH-1]}
                                            : w_trial[WIDTH-1:0];
                    r_cnt <= r_cnt - CW'(1);
                end
                ST_FIX: begin
                    if (r_dbz) begin
                        r_quo     <= '1;
                        r_rmd     <= r_q;
                        r_dbz_out <= 1'b1;
                    end else begin
                        r_quo     <= w_quo_fix;
                        r_rmd     <= w_rem_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quo;
    assign remainder   = r_rmd;
    assign div_by_zero = r_dbz_out;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=32 and WIDTH=8.
module tb_seq_divider;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    logic        Clock = 1'b0;
    logic        clr_n = 1'b0;
    always #5 Clock = ~Clock;

    logic        s32_start = 1'b0, s32_sgn = 1'b0;
    logic [31:0] s32_a = '0, s32_b = '0;
    logic        busy32, done32, dbz32;
    logic [31:0] q32, r32;

    logic        s8_start = 1'b0, s8_sgn = 1'b0;
    logic [7:0]  s8_a = '0, s8_b = '0;
    logic        busy8, done8, dbz8;
    logic [7:0]  q8, r8;

    exp_t sb32[$];
    exp_t sb8[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    seq_divider #(.WIDTH(32)) u_dut32 (
        .Clock(Clock), .clr_n(clr_n), .start(s32_start), .is_signed(s32_sgn),
        .dividend(s32_a), .divisor(s32_b), .busy(busy32), .done(done32),
        .quotient(q32), .remainder(r32), .div_by_zero(dbz32)
    );

    seq_divider #(.WIDTH(8)) u_dut8 (
        .Clock(Clock), .clr_n(clr_n), .start(s8_start), .is_signed(s8_sgn),
        .dividend(s8_a), .divisor(s8_b), .busy(busy8), .done(done8),
        .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge Clock) begin : monitor
        exp_t e;
        if (done32 === 1'b1) begin
            if (sb32.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done32: done high with no pending result");
            end else begin
                e = sb32.pop_front();
                chk("quotient32", q32, e.q);
                chk("remainder32", r32, e.r);
                chk("dbz32", {31'b0, dbz32}, {31'b0, e.dbz});
            end
        end
        if (done8 === 1'b1) begin
            if (sb8.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done8: done high with no pending result");
            end else begin
                e = sb8.pop_front();
                chk("quotient8", {24'b0, q8}, e.q);
                chk("remainder8", {24'b0, r8}, e.r);
                chk("dbz8", {31'b0, dbz8}, {31'b0, e.dbz});
            end
        end
    end

    function automatic logic sel_done(input bit w8);
        return w8 ? done8 : done32;
    endfunction

    function automatic logic sel_busy(input bit w8);
        return w8 ? busy8 : busy32;
    endfunction

    // Issue one divide, push its expected result, then verify latency and busy length
    task automatic run_op(input bit w8, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                          input bit glitch);
        exp_t e;
        int   n, nb, lat;
        lat   = edbz ? 2 : (w8 ? 10 : 34);
        e.q   = eq;
        e.r   = er;
        e.dbz = edbz;
        @(negedge Clock);
        if (w8) begin
            s8_start = 1'b1; s8_sgn = sgn; s8_a = a[7:0]; s8_b = b[7:0];
            sb8.push_back(e);
        end else begin
            s32_start = 1'b1; s32_sgn = sgn; s32_a = a; s32_b = b;
            sb32.push_back(e);
        end
        @(posedge Clock);
        #1;
        if (w8) begin
            s8_start = 1'b0; s8_sgn = ~sgn; s8_a = ~a[7:0]; s8_b = b[7:0] + 8'd3;
            chk("dbz8_cleared_on_start", {31'b0, dbz8}, 32'd0);
        end else begin
            s32_start = 1'b0; s32_sgn = ~sgn; s32_a = ~a; s32_b = b + 32'd3;
            chk("dbz32_cleared_on_start", {31'b0, dbz32}, 32'd0);
        end
        n  = 0;
        nb = 0;
        while (!sel_done(w8) && n < 200) begin
            if (sel_busy(w8)) nb++;
            if (glitch) begin
                if (w8) s8_start = (n == 3);
                else    s32_start = (n == 3);
            end
            @(posedge Clock);
            #1;
            n++;
        end
        s8_start  = 1'b0;
        s32_start = 1'b0;
        chk(w8 ? "latency8" : "latency32", n, lat);
        chk(w8 ? "busy_cycles8" : "busy_cycles32", nb, lat);
    endtask

    function automatic exp_t model8(input logic sgn, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   qa, ra;
        e.dbz = 1'b0;
        if (b == 8'd0) begin
            qa    = 255;
            ra    = int'(a);
            e.dbz = 1'b1;
        end else if (sgn) begin
            qa = int'($signed(a)) / int'($signed(b));
            ra = int'($signed(a)) % int'($signed(b));
        end else begin
            qa = int'(a) / int'(b);
            ra = int'(a) % int'(b);
        end
        e.q = {24'b0, qa[7:0]};
        e.r = {24'b0, ra[7:0]};
        return e;
    endfunction

    initial begin : stim
        exp_t e;
        logic [7:0] a8, b8;

        repeat (2) @(posedge Clock);
        #1;
        chk("reset_quotient32", q32, 32'd0);
        chk("reset_remainder32", r32, 32'd0);
        chk("reset_busy32", {31'b0, busy32}, 32'd0);
        chk("reset_done32", {31'b0, done32}, 32'd0);
        chk("reset_dbz32", {31'b0, dbz32}, 32'd0);
        chk("reset_quotient8", {24'b0, q8}, 32'd0);
        @(negedge Clock);
        clr_n = 1'b1;

        run_op(0, 1'b0, 32'h18, 32'h14, 32'h1, 32'h4, 1'b0, 0);
        run_op(0, 1'b1, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 0);
        run_op(0, 1'b1, 32'h7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1, 1'b0, 0);
        run_op(0, 1'b0, 32'h1234, 32'h0, 32'hFFFFFFFF, 32'h1234, 1'b1, 0);
        run_op(0, 1'b1, 32'hFFFFFF00, 32'h0, 32'hFFFFFFFF, 32'hFFFFFF00, 1'b1, 0);
        run_op(0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 1'b0, 0);
        run_op(0, 1'b0, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 0);

        repeat (3) @(posedge Clock);
        #1;
        chk("hold_quotient32", q32, 32'hFFFFFFFF);
        chk("hold_done32_low", {31'b0, done32}, 32'd0);

        // Abort an operation in its tenth ITER cycle
        @(negedge Clock);
        s32_start = 1'b1; s32_sgn = 1'b0; s32_a = 32'h55555555; s32_b = 32'h3;
        @(posedge Clock);
        #1;
        s32_start = 1'b0;
        repeat (10) @(posedge Clock);
        #1;
        chk("midop_busy32", {31'b0, busy32}, 32'd1);
        clr_n = 1'b0;
        #1;
        chk("midop_reset_quotient32", q32, 32'd0);
        chk("midop_reset_remainder32", r32, 32'd0);
        chk("midop_reset_busy32", {31'b0, busy32}, 32'd0);
        chk("midop_reset_done32", {31'b0, done32}, 32'd0);
        chk("midop_reset_dbz32", {31'b0, dbz32}, 32'd0);
        repeat (2) @(negedge Clock);
        clr_n = 1'b1;
        repeat (40) @(posedge Clock);
        run_op(0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 0);

        run_op(1, 1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0, 0);
        run_op(1, 1'b0, 32'd200, 32'd9, 32'd22, 32'd2, 1'b0, 1);
        run_op(1, 1'b1, 32'h80, 32'hFF, 32'h80, 32'h0, 1'b0, 0);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 32; i++) begin
                for (int j = 0; j < 32; j++) begin
                    a8 = 8'(i * 8 + i % 8);
                    b8 = 8'(j * 8 + (j * 3) % 8);
                    e  = model8(s == 1, a8, b8);
                    run_op(1, s == 1, {24'b0, a8}, {24'b0, b8}, e.q, e.r, e.dbz, 0);
                end
            end
        end

        repeat (5) @(posedge Clock);
        #1;
        chk("scoreboard32_drained", sb32.size(), 32'd0);
        chk("scoreboard8_drained", sb8.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
